// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_sequencer
// Description : Iterative 32-bit shifter (SLL/SRL/SRA/pass), STEP bits per
//               cycle, valid/ready on both sides plus pipeline flush.
//               Optional SHIFT-cycle counter when SHIFT_SEQ_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [1:0]  sel,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        busy
`ifdef SHIFT_SEQ_PERF_EN
  ,
  output logic [31:0] perf_cycles
`endif
);

  localparam logic [5:0] c_STEP = 6'(STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_data;
  logic [4:0]  r_rem;
  logic [1:0]  r_op;

  logic        w_load;
  logic        w_step;
  logic [5:0]  w_k;
  logic [4:0]  w_rem_next;
  logic [31:0] w_shifted;
  logic [4:0]  w_shamt;
  logic        w_unused_in2;

  assign w_shamt      = in2[4:0];
  assign w_unused_in2 = &{1'b0, in2[31:5]};

  // Step size this cycle: never overshoot the remaining amount.
  assign w_k        = ({1'b0, r_rem} > c_STEP) ? c_STEP : {1'b0, r_rem};
  assign w_rem_next = r_rem - w_k[4:0];

  always_comb begin
    w_shifted = r_data;
    case (r_op)
      2'b00:   w_shifted = r_data << w_k;
      2'b01:   w_shifted = r_data >> w_k;
      2'b10:   w_shifted = 32'($signed(r_data) >>> w_k);
      default: w_shifted = r_data;
    endcase
  end

  assign in_ready  = (r_state == S_IDLE) && !flush;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign out       = r_data;

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          w_load = 1'b1;
          w_next = ((w_shamt != 5'd0) && (sel != 2'b11)) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        w_step = 1'b1;
        if (w_rem_next == 5'd0) w_next = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Squash wins over every transition and suppresses any datapath update.
    if (flush) begin
      w_next = S_IDLE;
      w_load = 1'b0;
      w_step = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= 32'd0;
      r_rem  <= 5'd0;
      r_op   <= 2'd0;
    end else if (w_load) begin
      r_data <= in1;
      r_rem  <= w_shamt;
      r_op   <= sel;
    end else if (w_step) begin
      r_data <= w_shifted;
      r_rem  <= w_rem_next;
    end
  end

`ifdef SHIFT_SEQ_PERF_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf <= 32'd0;
    end else if (r_state == S_SHIFT) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_cycles = r_perf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_sequencer
// Description : Self-checking bench for shift_sequencer, directed plus random
//               operations against a behavioural result/latency model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in1 = 32'd0;
  logic [31:0] in2 = 32'd0;
  logic [1:0]  sel = 2'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out;
  logic        busy;
`ifdef SHIFT_SEQ_PERF_EN
  logic [31:0] perf_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.STEP(STEP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .sel       (sel),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
`ifdef SHIFT_SEQ_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [4:0] sh,
                                             input logic [1:0] op);
    logic signed [31:0] s;
    s = a;
    case (op)
      2'b00:   return a << sh;
      2'b01:   return a >> sh;
      2'b10:   return 32'(s >>> sh);
      default: return a;
    endcase
  endfunction

  function automatic int ref_cycles(input logic [4:0] sh, input logic [1:0] op);
    if (op == 2'b11 || sh == 5'd0) return 0;
    return (int'(sh) + STEP - 1) / STEP;
  endfunction

  // Issue one request from IDLE, then hold the result for 'hold' cycles.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input int hold);
    logic [31:0] exp;
    int          n;
    logic [31:0] perf0;
    exp   = ref_result(a, b[4:0], op);
    n     = ref_cycles(b[4:0], op);
    perf0 = 32'd0;
`ifdef SHIFT_SEQ_PERF_EN
    perf0 = perf_cycles;
`endif
    chk("accept_in_ready", in_ready, 1);
    in_valid  = 1'b1;
    in1       = a;
    in2       = b;
    sel       = op;
    out_ready = 1'($urandom);
    tick();
    for (int c = 1; c <= n; c++) begin
      chk("shift_out_valid", out_valid, 0);
      chk("shift_busy", busy, 1);
      in_valid  = 1'($urandom);
      in1       = $urandom;
      in2       = $urandom;
      sel       = 2'($urandom);
      out_ready = 1'($urandom);
      tick();
    end
    for (int c = 0; c <= hold; c++) begin
      chk("done_out_valid", out_valid, 1);
      chk("done_out", out, exp);
      chk("done_in_ready", in_ready, 0);
      chk("done_busy", busy, 1);
      if (c == hold) begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end else begin
        in_valid  = 1'($urandom);
        in1       = $urandom;
        in2       = $urandom;
        sel       = 2'($urandom);
        out_ready = 1'b0;
      end
      tick();
    end
    chk("idle_busy", busy, 0);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_in_ready", in_ready, 1);
`ifdef SHIFT_SEQ_PERF_EN
    chk("perf_delta", perf_cycles, perf0 + 32'(n));
`endif
    out_ready = 1'b0;
  endtask

  // SLL by 20 interrupted in cycle 5 by flush or reset.
  task automatic mid_abort(input bit use_rst);
    logic [31:0] perf0;
    perf0 = 32'd0;
`ifdef SHIFT_SEQ_PERF_EN
    perf0 = perf_cycles;
`endif
    in_valid  = 1'b1;
    in1       = $urandom;
    in2       = 32'd20;
    sel       = 2'b00;
    out_ready = 1'b1;
    tick();
    for (int c = 1; c <= 5; c++) begin
      chk("abort_out_valid", out_valid, 0);
      if (c == 5) begin
        in_valid = 1'b0;
        if (use_rst) rst = 1'b1;
        else         flush = 1'b1;
      end else begin
        in_valid = 1'($urandom);
      end
      tick();
    end
    rst   = 1'b0;
    flush = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_out_valid_after", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    if (use_rst) chk("rst_out", out, 0);
`ifdef SHIFT_SEQ_PERF_EN
    chk("abort_perf", perf_cycles, use_rst ? 32'd0 : perf0 + 32'd5);
`endif
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("abort_stays_idle", out_valid, 0);
    end
  endtask

  initial begin
    tick();
    tick();
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_out", out, 0);
`ifdef SHIFT_SEQ_PERF_EN
    chk("reset_perf", perf_cycles, 0);
`endif
    rst = 1'b0;
    tick();

    run_op(32'h8000_0000, 32'd4, 2'b10, 0);
    run_op(32'h0000_0001, 32'hFFFF_FFFF, 2'b00, 0);
    run_op(32'h1234_5678, 32'd0, 2'b01, 0);
    run_op(32'h1234_5678, 32'd7, 2'b11, 0);
    run_op(32'hF000_0000, 32'd8, 2'b01, 10);

    mid_abort(1'b0);
    mid_abort(1'b1);

    flush    = 1'b1;
    in_valid = 1'b1;
    in1      = 32'hDEAD_BEEF;
    in2      = 32'd3;
    sel      = 2'b00;
    #1;
    chk("flush_req_in_ready", in_ready, 0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_req_busy", busy, 0);
    chk("flush_req_out_valid", out_valid, 0);
    chk("flush_req_in_ready_after", in_ready, 1);
    tick();
    chk("flush_req_busy_later", busy, 0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] b;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b[4:0] = 5'd0;
      run_op($urandom, b, 2'($urandom), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift controller for the NPC execute stage. It accepts one shift operation per handshake (operand, shift amount, operation select) and performs the shift iteratively, STEP bit positions per clock, using a single small shift step instead of a full 32-bit barrel shifter. It sits between the issue/ALU control logic and writeback. It exposes valid/ready handshakes on both sides and a flush input for pipeline squash.

## Interface
Parameters:
- STEP, default 1: bit positions shifted per SHIFT cycle. Legal values are 1, 2, 4, 8, 16 and 32.

Ports:
- clk, input, 1: clock. Everything is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: request valid.
- in_ready, output, 1: block can accept a request.
- in1, input, 32: operand.
- in2, input, 32: shift amount source. Only in2[4:0] (shamt) is used; in2[31:5] is ignored.
- sel, input, 2: operation select.
  - 00: SLL.
  - 01: SRL.
  - 10: SRA.
  - 11: pass in1 unchanged.
- flush, input, 1: abort any in-flight operation.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts the result.
- out, output, 32: result. Held stable while out_valid is high.
- busy, output, 1: high whenever state is not IDLE.

## Operation
- **States:** IDLE, SHIFT, DONE.
- **Registers:** data[31:0], rem[4:0] (remaining shift amount), op[1:0].
- **IDLE**
  - in_ready = 1.
  - On in_valid & in_ready: data <= in1, rem <= shamt, op <= sel.
  - Next state is SHIFT if shamt != 0 and sel != 11; otherwise DONE.
- **SHIFT**, once per cycle:
  - k = min(STEP, rem).
  - data is shifted by k according to op: SLL fills with 0, SRL fills with 0, SRA fills with data[31].
  - rem <= rem - k.
  - When rem - k == 0, next state is DONE.
- **DONE**
  - out_valid = 1, out = data.
  - On out_ready: go to IDLE.
  - A new request is not accepted in the same cycle (in_ready = 0 in DONE).
- **Flush**
  - Has priority over all transitions except rst.
  - Next state is IDLE and any in-flight result is discarded.
  - A request presented in the same cycle as flush in IDLE is not accepted: in_ready is forced to 0 while flush = 1.
- **rst**
  - Has highest priority.
  - Resets state to IDLE and data, rem, op to 0, including in the middle of an operation.
- **Width rules**
  - Shifts are 32-bit logical/arithmetic per RV32I.
  - A shamt of 31 is legal; there is no modulo beyond in2[4:0].
- **Inputs ignored**
  - in_valid is ignored outside IDLE.
  - in1, in2 and sel are sampled only at acceptance. Changing them afterwards has no effect.

## Timing
- **Reset values:** in_ready = 1, out_valid = 0, busy = 0, out = 0.
- **Latency:** let cycle 0 be the accept cycle and N = ceil(shamt/STEP), with N = 0 when sel = 11 or shamt = 0.
  - out_valid is first high in cycle N+1.
  - busy is high from cycle 1 until the cycle in which out_valid & out_ready occurs, inclusive.
- **Throughput:** at most one request per N+2 cycles when out_ready is held high. The extra cycle is the return to IDLE.
- **Backpressure:** out_valid and out hold indefinitely while out_ready = 0.
- **STEP = 32:** any nonzero shift completes in a single SHIFT cycle.
- **Output timing:** all outputs are registered state decodes. There is no combinational path from in_valid or out_ready to any output, except in_ready depending on flush.

## Configuration
- **SHIFT_SEQ_PERF_EN defined:**
  - Adds output port perf_cycles [31:0].
  - perf_cycles increments on every cycle the block is in SHIFT.
  - It wraps from 0xFFFFFFFF to 0.
  - It resets to 0 on rst and is unaffected by flush.
- **SHIFT_SEQ_PERF_EN not defined:**
  - The port and the counter are absent.
  - Functional behaviour is otherwise identical.

## Test plan
- **SRA:** STEP=1, in1=0x80000000, in2=4, sel=10, out_ready=1. Required: out=0xF8000000, out_valid high in cycle 5, in_ready high again in cycle 6.
- **SLL, STEP=4:** in1=0x00000001, in2=0xFFFFFFFF (shamt=31), sel=00. Required: out=0x80000000, out_valid in cycle 9 (N=8, last step k=3).
- **Zero shift and pass:** in1=0x12345678 with in2=0, sel=01; then a separate request with in2=7, sel=11. Required: each returns out=0x12345678 with out_valid in cycle 1 and no SHIFT cycles (perf_cycles unchanged when SHIFT_SEQ_PERF_EN is defined).
- **Backpressure:** SRL of 0xF0000000 by 8, out_ready=0 for 10 cycles after out_valid. Required:
  - out stays 0x00F00000.
  - in_ready stays 0 and a new in_valid is ignored.
  - The result completes on the first out_ready=1 cycle.
- **Flush and reset mid-operation:** STEP=1, SLL by 20.
  - Assert flush in cycle 5. Required: IDLE in cycle 6, out_valid never asserted, in_ready=1.
  - Repeat with rst in cycle 5. Required: all outputs at their reset values in cycle 6.
- **Flush with request:** flush and in_valid both high in IDLE. Required: request not accepted, busy stays 0.
